ps2_key_decoder: RTL and testbench

//  Receive-only PS/2 keyboard front end (Set 2 scan codes) producing the key-state interface the game logic consumes.

---
 rtl/ps2_key_decoder.sv | 130 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set 2 receiver with E0/F0 prefix tracking and a held-key bitmap.
// Optional KBD_REPEAT_FILTER_EN suppresses strobes for typematic repeats of already-held keys.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t state, state_d;
  logic [1:0] clk_s, dat_s;
  logic filt_clk, fall, byte_done, tmo, good, discard, ext, brk, rep;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par;
  logic [8:0] code;
  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  assign fall = filt_clk & ~clk_s[1] & (filt_cnt == F_MAX);
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s    <= 2'b11;
      dat_s    <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      if (clk_s[1] == filt_clk)
        filt_cnt <= '0;
      else if (filt_cnt == F_MAX) begin
        filt_clk <= clk_s[1];
        filt_cnt <= '0;
      end else
        filt_cnt <= filt_cnt + 1'b1;
    end
  end
  always_comb begin
    state_d   = state;
    byte_done = 1'b0;
    tmo       = 1'b0;
    if (state != RX_IDLE && !fall && tmo_cnt == T_MAX) begin
      state_d = RX_IDLE;
      tmo     = 1'b1;
    end else if (fall) begin
      case (state)
        RX_IDLE: state_d = dat_s[1] ? RX_IDLE : RX_DATA;
        RX_DATA: state_d = (bit_cnt == 3'd7) ? RX_PAR : RX_DATA;
        RX_PAR:  state_d = RX_STOP;
        default: begin
          state_d   = RX_IDLE;
          byte_done = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= RX_IDLE;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_d;
      tmo_cnt <= (state == RX_IDLE || fall) ? '0 : (tmo_cnt == T_MAX ? tmo_cnt : tmo_cnt + 1'b1);
      if (fall && state == RX_IDLE)
        bit_cnt <= '0;
      if (fall && state == RX_DATA) begin
        shreg   <= {dat_s[1], shreg[7:1]};
        bit_cnt <= (bit_cnt == 3'd7) ? bit_cnt : bit_cnt + 1'b1;
      end
      if (fall && state == RX_PAR)
        par <= dat_s[1];
    end
  end
  // Odd parity over data+parity, and the stop bit sampled on this edge must be 1
  assign good    = dat_s[1] & ^{shreg, par};
  assign discard = shreg inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
  assign code    = {ext, shreg};
`ifdef KBD_REPEAT_FILTER_EN
  assign rep = ~brk & key_down[code];
`else
  assign rep = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (tmo || (byte_done && !good)) begin
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (byte_done) begin
        if (shreg == 8'hE0)
          ext <= 1'b1;
        else if (shreg == 8'hF0)
          brk <= 1'b1;
        else if (!discard) begin
          if (!rep) begin
            key_down[code] <= ~brk;
            last_change    <= code;
            key_valid      <= 1'b1;
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frames against a key-state reference model with a strobe scoreboard.
module tb_ps2_key_decoder;
  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 30;
  logic pclk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [511:0] key_down;
  logic [8:0] last_change;
  logic key_valid, frame_err;
  int checks = 0, errors = 0;
  bit [511:0] m_map = '0;
  bit [8:0] m_last = '0;
  bit m_ext = 0, m_brk = 0;
  bit q_err[$];
  bit [8:0] q_code[$];
  bit [511:0] q_map[$];
  logic [7:0] pool [6] = '{8'h1C, 8'h29, 8'h75, 8'h6B, 8'h5A, 8'h12};
  logic [7:0] junk [7] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_down(key_down), .last_change(last_change), .key_valid(key_valid), .frame_err(frame_err));

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (!rst && (key_valid || frame_err)) begin
      chk("exclusive", {511'd0, key_valid & frame_err}, 512'd0);
      if (q_err.size() == 0)
        chk("unexpected_strobe", {510'd0, key_valid, frame_err}, 512'd0);
      else begin
        chk("strobe_kind", {511'd0, frame_err}, {511'd0, q_err[0]});
        chk("last_change", {503'd0, last_change}, {503'd0, q_code[0]});
        chk("key_down", key_down, q_map[0]);
        void'(q_err.pop_front());
        void'(q_code.pop_front());
        void'(q_map.pop_front());
      end
    end
  end

  function automatic void push(input bit e);
    q_err.push_back(e);
    q_code.push_back(m_last);
    q_map.push_back(m_map);
  endfunction

  function automatic void model(input logic [7:0] b, input bit bad);
    bit [8:0] c;
    bit repeat_hit;
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
      push(1);
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1})) begin
      c = {m_ext, b};
`ifdef KBD_REPEAT_FILTER_EN
      repeat_hit = !m_brk && m_map[c];
`else
      repeat_hit = 0;
`endif
      if (!repeat_hit) begin
        m_map[c] = !m_brk;
        m_last = c;
        push(0);
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic send_bit(input logic v, input bit glitch);
    int g;
    ps2_data = v;
    if (glitch) begin
      g = $urandom_range(1, FL - 2);
      repeat (5) @(posedge pclk);
      ps2_clk = 0;
      repeat (g) @(posedge pclk);
      ps2_clk = 1;
      repeat (HALF - 5 - g) @(posedge pclk);
    end else
      repeat (HALF) @(posedge pclk);
    ps2_clk = 0;
    repeat (HALF) @(posedge pclk);
    ps2_clk = 1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input bit glitch);
    logic [10:0] f;
    model(b, bad);
    f = {1'b1, (^b) ^ ~bad, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch && ($urandom_range(0, 2) == 0));
    ps2_data = 1;
    repeat (2 * HALF) @(posedge pclk);
  endtask

  initial begin
    repeat (4) @(posedge pclk);
    rst = 0;
    @(negedge pclk);
    chk("rst_key_down", key_down, '0);
    chk("rst_last", {503'd0, last_change}, '0);
    chk("rst_valid", {511'd0, key_valid}, '0);
    chk("rst_err", {511'd0, frame_err}, '0);
    send(8'h29, 0, 0);
    send(8'hF0, 0, 0); send(8'h29, 0, 0);
    send(8'hE0, 0, 0); send(8'h75, 0, 0);
    send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
    send(8'h1C, 1, 0); send(8'h1C, 0, 0);
    send(8'hAA, 0, 0); send(8'hFA, 0, 1);
    send_bit(1'b1, 0);
    repeat (2 * HALF) @(posedge pclk);
    push(1);
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'(i & 1), 0);
    repeat (TMO + 200) @(posedge pclk);
    send(8'h29, 0, 1);
    send(8'h29, 0, 1); send(8'h29, 0, 1);
    send(8'hF0, 0, 0); send(8'h29, 0, 0);
    for (int i = 0; i < 36; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: send(8'hE0, 0, 1);
        1: send(8'hF0, 0, 1);
        2: send(junk[$urandom_range(0, 6)], 0, 1);
        3: send(pool[$urandom_range(0, 5)], 1, 1);
        default: send(pool[$urandom_range(0, 5)], 0, 1);
      endcase
    end
    repeat (50) @(posedge pclk);
    chk("queue_drained", 512'(q_err.size()), '0);
    chk("final_key_down", key_down, m_map);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
